// File: rtl/osecpu_pkg.sv
// Shared OSECPU definitions: default memory geometry and read-return owner encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package osecpu_pkg;

  localparam int AW_DEF = 16;  // memory address width, same as pc width
  localparam int DW_DEF = 32;  // memory data width

  // Which requester the read data arriving this cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Two-way priority pick between data (DM) and fetch (IF) with a burst override for IF.
// Latency: purely combinational, grant in the same cycle as the request.
// Backpressure: a requester that is not granted simply keeps its request up.
// Ports:
//   arb_en_i     grants are only issued while high (held low during reset)
//   if_req_i     fetch request
//   dm_req_i     data request
//   burst_cnt_i  consecutive DM grants taken while IF was waiting
//   if_gnt_o     fetch granted
//   dm_gnt_o     data granted
module mem_arb_prio #(
  parameter int DM_BURST = 4,
  parameter int CW       = $clog2(DM_BURST + 1)
) (
  input  logic          arb_en_i,
  input  logic          if_req_i,
  input  logic          dm_req_i,
  input  logic [CW-1:0] burst_cnt_i,
  output logic          if_gnt_o,
  output logic          dm_gnt_o
);

  always_comb begin
    if_gnt_o = 1'b0;
    dm_gnt_o = 1'b0;
    if (arb_en_i) begin
      // DM wins unless IF is waiting and DM has used up its burst allowance.
      if (dm_req_i && (!if_req_i || (burst_cnt_i < CW'(DM_BURST)))) begin
        dm_gnt_o = 1'b1;
      end else if (if_req_i) begin
        if_gnt_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/osecpu_mem_arbiter.sv
// Shares the single-port Memory between instruction fetch (IF) and data load/store (DM).
// Latency: grant same cycle as request; read data exactly one cycle after the grant, fully pipelined.
// Backpressure: requesters hold req/addr/data until their gnt; DM has priority, IF gets a slot after DM_BURST.
// Ports:
//   clk, reset                         clock; synchronous active-high reset
//   if_req/if_addr -> if_gnt           fetch request and its same-cycle grant
//   if_rvalid/if_rdata                 fetch data, one cycle after if_gnt
//   dm_req/dm_we/dm_addr/dm_wdata      data request (store when dm_we=1)
//   dm_gnt, dm_rvalid/dm_rdata         data grant; load data one cycle after a load grant
//   mem_addr/mem_wdata/mem_we          Memory request port
//   mem_rdata                          Memory synchronous read data
module osecpu_mem_arbiter
  import osecpu_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int DM_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(DM_BURST + 1);

  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  rd_owner_e     rd_owner_q,  rd_owner_d;

  mem_arb_prio #(
    .DM_BURST (DM_BURST),
    .CW       (CW)
  ) u_prio (
    .arb_en_i    (~reset),
    .if_req_i    (if_req),
    .dm_req_i    (dm_req),
    .burst_cnt_i (burst_cnt_q),
    .if_gnt_o    (if_gnt),
    .dm_gnt_o    (dm_gnt)
  );

  // Memory port follows whichever requester holds the grant; idle drives zeros.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (dm_gnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      mem_we    = dm_we;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // Count DM grants only while IF is actually waiting; IF being served or
  // going away restarts the allowance.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (if_gnt || !if_req) begin
      burst_cnt_d = '0;
    end else if (dm_gnt && (burst_cnt_q != CW'(DM_BURST))) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  // Stores produce no read return.
  always_comb begin
    rd_owner_d = OWN_NONE;
    if (if_gnt) begin
      rd_owner_d = OWN_IF;
    end else if (dm_gnt && !dm_we) begin
      rd_owner_d = OWN_DM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt_q <= '0;
      rd_owner_q  <= OWN_NONE;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      rd_owner_q  <= rd_owner_d;
    end
  end

  // Reset also masks a return already in flight so it is never seen by the owner.
  assign if_rvalid = (rd_owner_q == OWN_IF) && !reset;
  assign dm_rvalid = (rd_owner_q == OWN_DM) && !reset;
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

endmodule

// File: tb/tb_osecpu_mem_arbiter.sv
// Self-checking bench for osecpu_mem_arbiter with a behavioural synchronous Memory.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: n/a (directed vectors).
module tb_osecpu_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  osecpu_mem_arbiter #(.AW(AW), .DW(DW), .DM_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // Memory model: unwritten words read as 0xC0DE0000 | addr; read-before-write.
  logic [31:0] mem [int];
  always @(posedge clk) begin
    int a;
    a = int'(mem_addr);
    mem_rdata <= mem.exists(a) ? mem[a] : (32'hC0DE_0000 | 32'(mem_addr));
    if (mem_we) mem[a] = mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        ireq;
    logic [15:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [15:0] daddr;
    logic [31:0] dwdata;
    logic        e_ig;
    logic        e_dg;
    logic        e_we;
    logic [15:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_irv;
    logic        e_drv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    logic rst, logic ireq, logic [15:0] iaddr, logic dreq, logic dwe, logic [15:0] daddr,
    logic [31:0] dwdata, logic e_ig, logic e_dg, logic e_we, logic [15:0] e_addr,
    logic [31:0] e_wdata, logic e_irv, logic e_drv, logic [31:0] e_rdata);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe;
    v.daddr = daddr; v.dwdata = dwdata; v.e_ig = e_ig; v.e_dg = e_dg; v.e_we = e_we;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_irv = e_irv; v.e_drv = e_drv;
    v.e_rdata = e_rdata;
    return v;
  endfunction

  // Contention row: IF at 0x0010, DM at 0x0020 (load) or 0x0030 (store of 0x55AA0000).
  // g_if says who is expected to win; p_if/p_dm say whose read returns this cycle.
  function automatic vec_t cont(logic st, logic g_if, logic p_if, logic p_dm);
    logic [15:0] da;
    logic [31:0] dw;
    da = st ? 16'h0030 : 16'h0020;
    dw = st ? 32'h55AA_0000 : 32'h0;
    return mk(0, 1, 16'h0010, 1, st, da, dw,
              g_if, !g_if, !g_if && st, g_if ? 16'h0010 : da, g_if ? 32'h0 : dw,
              p_if, p_dm, p_if ? 32'hC0DE_0010 : 32'hC0DE_0020);
  endfunction

  task automatic apply(input vec_t v, input int idx);
    string s;
    @(negedge clk);
    reset = v.rst; if_req = v.ireq; if_addr = v.iaddr; dm_req = v.dreq;
    dm_we = v.dwe; dm_addr = v.daddr; dm_wdata = v.dwdata;
    #1;
    s = $sformatf("row%0d", idx);
    chk({s, ".if_gnt"},    32'(if_gnt),    32'(v.e_ig));
    chk({s, ".dm_gnt"},    32'(dm_gnt),    32'(v.e_dg));
    chk({s, ".one_gnt"},   32'(if_gnt & dm_gnt), 32'(0));
    chk({s, ".mem_we"},    32'(mem_we),    32'(v.e_we));
    chk({s, ".mem_addr"},  32'(mem_addr),  32'(v.e_addr));
    chk({s, ".mem_wdata"}, mem_wdata,      v.e_wdata);
    chk({s, ".if_rvalid"}, 32'(if_rvalid), 32'(v.e_irv));
    chk({s, ".dm_rvalid"}, 32'(dm_rvalid), 32'(v.e_drv));
    if (v.e_irv) chk({s, ".if_rdata"}, if_rdata, v.e_rdata);
    if (v.e_drv) chk({s, ".dm_rdata"}, dm_rdata, v.e_rdata);
  endtask

  initial begin
    reset = 1'b1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;

    // Reset: requests present but nothing granted.
    vq.push_back(mk(1, 1, 16'h0005, 1, 1, 16'h0006, 32'h1, 0, 0, 0, 16'h0, 32'h0, 0, 0, 0));
    // IF only, four sequential fetches.
    vq.push_back(mk(0, 1, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 16'h0001, 0, 0, 0, 0, 1, 0, 0, 16'h0001, 0, 1, 0, 32'hC0DE_0000));
    vq.push_back(mk(0, 1, 16'h0002, 0, 0, 0, 0, 1, 0, 0, 16'h0002, 0, 1, 0, 32'hC0DE_0001));
    vq.push_back(mk(0, 1, 16'h0003, 0, 0, 0, 0, 1, 0, 0, 16'h0003, 0, 1, 0, 32'hC0DE_0002));
    vq.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 32'hC0DE_0003));
    // DM store then load of the same address, then idle to see the load data.
    vq.push_back(mk(0, 0, 0, 1, 1, 16'h0100, 32'hDEAD_BEEF, 0, 1, 1, 16'h0100, 32'hDEAD_BEEF, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 16'h0100, 32'h0, 0, 1, 0, 16'h0100, 32'h0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 32'h0, 0, 0, 0, 16'h0000, 32'h0, 0, 1, 32'hDEAD_BEEF));
    // Load contention: D,D,D,D,I,D,D,D,D,I,D,D then idle.
    vq.push_back(cont(0, 0, 0, 0));
    vq.push_back(cont(0, 0, 0, 1));
    vq.push_back(cont(0, 0, 0, 1));
    vq.push_back(cont(0, 0, 0, 1));
    vq.push_back(cont(0, 1, 0, 1));
    vq.push_back(cont(0, 0, 1, 0));
    vq.push_back(cont(0, 0, 0, 1));
    vq.push_back(cont(0, 0, 0, 1));
    vq.push_back(cont(0, 0, 0, 1));
    vq.push_back(cont(0, 1, 0, 1));
    vq.push_back(cont(0, 0, 1, 0));
    vq.push_back(cont(0, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 1, 32'hC0DE_0020));
    // Store contention: no dm_rvalid ever, IF every fifth cycle.
    vq.push_back(cont(1, 0, 0, 0));
    vq.push_back(cont(1, 0, 0, 0));
    vq.push_back(cont(1, 0, 0, 0));
    vq.push_back(cont(1, 0, 0, 0));
    vq.push_back(cont(1, 1, 0, 0));
    vq.push_back(cont(1, 0, 1, 0));
    vq.push_back(cont(1, 0, 0, 0));
    vq.push_back(cont(1, 0, 0, 0));
    vq.push_back(cont(1, 0, 0, 0));
    vq.push_back(cont(1, 1, 0, 0));
    // Idle: zero port, the last IF read returns.
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 1, 0, 32'hC0DE_0010));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 32'h0));

    foreach (vq[i]) apply(vq[i], i);

    // Reset in the cycle after a load grant, with the burst counter at its limit.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      reset = 0; if_req = 1; if_addr = 16'h0010; dm_req = 1; dm_we = 0; dm_addr = 16'h0020;
      dm_wdata = '0;
      #1;
      chk($sformatf("rst_seq.dm_gnt%0d", k), 32'(dm_gnt), 32'd1);
    end
    @(negedge clk);
    reset = 1;
    #1;
    chk("rst_seq.dm_rvalid_in_reset", 32'(dm_rvalid), 32'd0);
    chk("rst_seq.if_gnt_in_reset",    32'(if_gnt),    32'd0);
    chk("rst_seq.dm_gnt_in_reset",    32'(dm_gnt),    32'd0);
    chk("rst_seq.mem_we_in_reset",    32'(mem_we),    32'd0);
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_seq.dm_rvalid_after", 32'(dm_rvalid), 32'd0);
    chk("rst_seq.if_rvalid_after", 32'(if_rvalid), 32'd0);
    // Counter was cleared, so DM wins again instead of IF.
    chk("rst_seq.dm_gnt_after",    32'(dm_gnt),    32'd1);
    chk("rst_seq.if_gnt_after",    32'(if_gnt),    32'd0);
    @(negedge clk);
    if_req = 0; dm_req = 0;
    #1;
    chk("rst_seq.dm_rvalid_tail", 32'(dm_rvalid), 32'd1);
    chk("rst_seq.dm_rdata_tail",  dm_rdata,       32'hC0DE_0020);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
